// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Cathode patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic {BLANK, DRIVE} state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex glyphs 0..F
  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_decode.sv
// Nibble to active-low cathode pattern, purely combinational.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] cat
);

  // Table lookup of the hex glyph
  always_comb begin
    cat = GLYPHS[nibble];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a blanking gap before each
// digit and a double-buffered display word committed only at frame boundaries.
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIV_COUNT    = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic                      load,
  output logic                      load_ack,
  output logic                      frame_start,
  output logic [NUM_DIGITS-1:0]     seg_an,
  output logic [6:0]                seg_cat
);

  localparam int unsigned CntMax = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned DataW  = 4 * NUM_DIGITS;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DataW-1:0]  disp_q, disp_d;
  logic [DataW-1:0]  pend_q, pend_d;
  logic              pend_flag_q, pend_flag_d;
  logic              ack_d, fs_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]        cat_d;
  logic [3:0]        nibble;
  logic [6:0]        glyph;

  // Scan sequencing, prescaler and double-buffer commit
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = load ? digits_in : pend_q;
    pend_flag_d = pend_flag_q | load;
    ack_d       = 1'b0;
    fs_d        = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == CntW'(DIV_COUNT - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
            idx_d = '0;
            fs_d  = 1'b1;
            // Commit uses pending from before this edge; a same-edge load stays pending
            if (pend_flag_q) begin
              disp_d      = pend_q;
              ack_d       = 1'b1;
              pend_flag_d = load;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Select the nibble of the digit that will be active after this edge
  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IdxW'(i)) nibble = disp_d[4*i +: 4];
    end
  end

  seg_decode u_decode (
    .nibble (nibble),
    .cat    (glyph)
  );

`ifdef SEG_SCAN_LZB_EN
  logic lead_zero;

  // Digit is a leading zero when it and every more-significant nibble are 0
  always_comb begin
    lead_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IdxW'(i) >= idx_d && disp_d[4*i +: 4] != 4'h0) lead_zero = 1'b0;
    end
  end
`endif

  // Output patterns computed from next state so outputs are registered
  always_comb begin
    an_d = '1;
    if (state_d == DRIVE) an_d[idx_d] = 1'b0;
    cat_d = glyph;
`ifdef SEG_SCAN_LZB_EN
    if (idx_d != '0 && lead_zero) cat_d = SEG_OFF;
`endif
  end

  // State, buffers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      seg_an      <= '1;
      seg_cat     <= SEG_OFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      load_ack    <= ack_d;
      frame_start <= fs_d;
      seg_an      <= an_d;
      seg_cat     <= cat_d;
    end
  end

endmodule
